// File: rtl/bram_arb_pkg.sv
// bram_arb_pkg: shared widths, arbiter states and read-tag type for the BRAM port arbiter
package bram_arb_pkg;
  localparam int ADDR_W = 13;
  localparam int DATA_W = 8;
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_state_t;
  typedef struct packed {
    logic valid;
    logic owner;
  } rd_tag_t;
endpackage

// File: rtl/bram_rd_tag_pipe.sv
// bram_rd_tag_pipe: delays read tags by the BRAM read latency and decodes them into per-requester rvalid pulses
module bram_rd_tag_pipe
  import bram_arb_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic       clk,
  input  logic       rst_n_sync,
  input  rd_tag_t    i_tag,
  output logic       o_head_valid,
  output logic [1:0] o_rvalid
);
  rd_tag_t    r_pipe [RD_LATENCY];
  logic [1:0] r_rvalid;
  always_ff @(posedge clk or negedge rst_n_sync)
    if (!rst_n_sync) begin
      for (int k = 0; k < RD_LATENCY; k++) r_pipe[k] <= '0;
      r_rvalid <= '0;
    end else begin
      r_pipe[0] <= i_tag;
      for (int k = 1; k < RD_LATENCY; k++) r_pipe[k] <= r_pipe[k-1];
      r_rvalid <= {r_pipe[RD_LATENCY-1].valid & r_pipe[RD_LATENCY-1].owner,
                   r_pipe[RD_LATENCY-1].valid & ~r_pipe[RD_LATENCY-1].owner};
    end
  assign o_head_valid = r_pipe[RD_LATENCY-1].valid;
  assign o_rvalid     = r_rvalid;
endmodule

// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: round-robin sharing of one BRAM port between two requesters,
// with burst lock, burst cap, registered BRAM controls and tagged read-data return.
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int ADDR_W     = 13,
  parameter int DATA_W     = 8,
  parameter int RD_LATENCY = 1,
  parameter int MAX_BURST  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n_sync,
  input  logic [1:0]             req_i,
  input  logic [1:0]             lock_i,
  input  logic [1:0]             wen_i,
  input  logic [1:0][ADDR_W-1:0] addr_i,
  input  logic [1:0][DATA_W-1:0] wdata_i,
  output logic [1:0]             gnt_o,
  output logic [1:0]             rvalid_o,
  output logic [DATA_W-1:0]      rdata_o,
  input  logic [DATA_W-1:0]      bram_read_data,
  output logic [ADDR_W-1:0]      bram_addr,
  output logic [DATA_W-1:0]      bram_write_data,
  output logic                   bram_wen,
  output logic                   bram_ren
);
  localparam logic [7:0] CAP = 8'(MAX_BURST - 1);
  arb_state_t        r_state, w_state_nx;
  logic              r_last, w_last_nx;
  logic [7:0]        r_cnt, w_cnt_nx;
  logic [1:0]        w_gnt;
  logic              w_own, w_sel, w_xfer, w_cap;
  rd_tag_t           w_tag;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata, r_rdata;
  logic              r_wen, r_ren;
  always_comb begin
    w_own      = r_state == OWN1;
    w_gnt      = r_state == OWN0 ? 2'b01 : r_state == OWN1 ? 2'b10 :
                 &req_i ? (r_last ? 2'b01 : 2'b10) : req_i;
    w_sel      = w_gnt[1];
    w_xfer     = |(req_i & w_gnt);
    w_tag      = '{valid: w_xfer & ~wen_i[w_sel], owner: w_sel};
    w_state_nx = r_state;
    w_last_nx  = r_last;
    w_cnt_nx   = r_cnt;
    if (r_state == IDLE) begin
      if (w_xfer) begin
        w_state_nx = w_sel ? OWN1 : OWN0;
        w_last_nx  = w_sel;
        w_cnt_nx   = 8'd1;
      end
    end else if (!lock_i[w_own]) begin
      // hand over when the owner goes quiet, or when it hits the cap with the other side waiting
      if (req_i[!w_own] && (!req_i[w_own] || r_cnt == CAP)) begin
        w_state_nx = w_own ? OWN0 : OWN1;
        w_last_nx  = !w_own;
        w_cnt_nx   = '0;
      end else if (!req_i[w_own]) w_state_nx = IDLE;
      else if (r_cnt != CAP) w_cnt_nx = r_cnt + 8'd1;
    end
  end
  always_ff @(posedge clk or negedge rst_n_sync)
    if (!rst_n_sync) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_last  <= w_last_nx;
      r_cnt   <= w_cnt_nx;
    end
  always_ff @(posedge clk or negedge rst_n_sync)
    if (!rst_n_sync) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_wen   <= 1'b0;
      r_ren   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_wen <= w_xfer & wen_i[w_sel];
      r_ren <= w_xfer & ~wen_i[w_sel];
      if (w_xfer) begin
        r_addr  <= addr_i[w_sel];
        r_wdata <= wdata_i[w_sel];
      end
      if (w_cap) r_rdata <= bram_read_data;
    end
  bram_rd_tag_pipe #(.RD_LATENCY(RD_LATENCY)) u_tag_pipe (
    .clk          (clk),
    .rst_n_sync   (rst_n_sync),
    .i_tag        (w_tag),
    .o_head_valid (w_cap),
    .o_rvalid     (rvalid_o)
  );
  assign gnt_o           = w_gnt;
  assign rdata_o         = r_rdata;
  assign bram_addr       = r_addr;
  assign bram_write_data = r_wdata;
  assign bram_wen        = r_wen;
  assign bram_ren        = r_ren;
endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb_bram_port_arbiter: two arbiters (RD_LATENCY 1 and 3, MAX_BURST 4) on identical stimulus,
// each with its own BRAM model; read returns are scoreboarded by due cycle.
module tb_bram_port_arbiter;
  logic             clk = 1'b0;
  logic             rst_n_sync;
  logic [1:0]       req, lock, wen;
  logic [1:0][12:0] addr;
  logic [1:0][7:0]  wdata;
  logic [1:0]       gnt_a, gnt_b, rvalid_a, rvalid_b;
  logic [7:0]       rdata_a, rdata_b, bram_rd_a, bram_rd_b, bwd_a, bwd_b, d1_b, d2_b;
  logic [12:0]      baddr_a, baddr_b;
  logic             bwen_a, bwen_b, bren_a, bren_b;
  logic [7:0]       mem_a [0:8191];
  logic [7:0]       mem_b [0:8191];
  logic [7:0]       ref_mem [0:8191];
  typedef struct {logic owner; logic [7:0] data; int due;} exp_t;
  exp_t qa[$], qb[$];
  int checks = 0, errors = 0, cyc_cnt = 0;
  logic [1:0] ea, eb;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt++;

  bram_port_arbiter #(.RD_LATENCY(1), .MAX_BURST(4)) u_a (
    .clk(clk), .rst_n_sync(rst_n_sync), .req_i(req), .lock_i(lock), .wen_i(wen),
    .addr_i(addr), .wdata_i(wdata), .gnt_o(gnt_a), .rvalid_o(rvalid_a), .rdata_o(rdata_a),
    .bram_read_data(bram_rd_a), .bram_addr(baddr_a), .bram_write_data(bwd_a),
    .bram_wen(bwen_a), .bram_ren(bren_a));
  bram_port_arbiter #(.RD_LATENCY(3), .MAX_BURST(4)) u_b (
    .clk(clk), .rst_n_sync(rst_n_sync), .req_i(req), .lock_i(lock), .wen_i(wen),
    .addr_i(addr), .wdata_i(wdata), .gnt_o(gnt_b), .rvalid_o(rvalid_b), .rdata_o(rdata_b),
    .bram_read_data(bram_rd_b), .bram_addr(baddr_b), .bram_write_data(bwd_b),
    .bram_wen(bwen_b), .bram_ren(bren_b));

  // latency-1 BRAM presents data in the ren cycle; latency-3 BRAM two cycles later
  assign bram_rd_a = mem_a[baddr_a];
  assign bram_rd_b = d2_b;
  always @(posedge clk) begin
    if (bwen_a) mem_a[baddr_a] <= bwd_a;
    if (bwen_b) mem_b[baddr_b] <= bwd_b;
    d1_b <= mem_b[baddr_b];
    d2_b <= d1_b;
  end

  task automatic chk(input string t, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", t, got, exp);
    end
  endtask

  task automatic g(input string t, input logic [1:0] e);
    chk({t, "_a"}, 32'(gnt_a), 32'(e));
    chk({t, "_b"}, 32'(gnt_b), 32'(e));
  endtask

  task automatic ctl(input string t, input logic we, input logic re, input logic [12:0] a);
    chk({t, "_a"}, 32'({bwen_a, bren_a, baddr_a}), 32'({we, re, a}));
    chk({t, "_b"}, 32'({bwen_b, bren_b, baddr_b}), 32'({we, re, a}));
  endtask

  task automatic wd(input string t, input logic [7:0] d);
    chk({t, "_a"}, 32'(bwd_a), 32'(d));
    chk({t, "_b"}, 32'(bwd_b), 32'(d));
  endtask

  task automatic quiet(input string t);
    chk({t, "_a"}, 32'({bwen_a, bren_a}), 32'(0));
    chk({t, "_b"}, 32'({bwen_b, bren_b}), 32'(0));
  endtask

  task automatic push_rd(input logic o, input logic [12:0] a);
    qa.push_back('{o, ref_mem[a], cyc_cnt + 2});
    qb.push_back('{o, ref_mem[a], cyc_cnt + 4});
  endtask

  task automatic cyc(input logic [1:0] r, input logic [1:0] l, input logic [1:0] w,
                     input logic [12:0] a0, input logic [12:0] a1,
                     input logic [7:0] d0, input logic [7:0] d1);
    @(posedge clk);
    #1;
    req = r; lock = l; wen = w;
    addr[0] = a0; addr[1] = a1; wdata[0] = d0; wdata[1] = d1;
    #2;
  endtask

  task automatic nop();
    cyc(2'b00, 2'b00, 2'b00, 13'h0, 13'h0, 8'h0, 8'h0);
  endtask

  always @(negedge clk)
    if (rst_n_sync) begin
      ea = (qa.size() > 0 && qa[0].due == cyc_cnt) ? (qa[0].owner ? 2'b10 : 2'b01) : 2'b00;
      eb = (qb.size() > 0 && qb[0].due == cyc_cnt) ? (qb[0].owner ? 2'b10 : 2'b01) : 2'b00;
      if (ea != 0 || rvalid_a != 0) chk("rvalid_a", 32'(rvalid_a), 32'(ea));
      if (eb != 0 || rvalid_b != 0) chk("rvalid_b", 32'(rvalid_b), 32'(eb));
      if (ea != 0) begin
        chk("rdata_a", 32'(rdata_a), 32'(qa[0].data));
        void'(qa.pop_front());
      end
      if (eb != 0) begin
        chk("rdata_b", 32'(rdata_b), 32'(qb[0].data));
        void'(qb.pop_front());
      end
    end

  initial begin
    rst_n_sync = 1'b0;
    req = '0; lock = '0; wen = '0; addr = '0; wdata = '0;
    for (int i = 0; i < 8192; i++) begin
      mem_a[i] = 8'(i * 7 + 3);
      mem_b[i] = 8'(i * 7 + 3);
      ref_mem[i] = 8'(i * 7 + 3);
    end
    mem_a[16] = 8'hA5; mem_b[16] = 8'hA5; ref_mem[16] = 8'hA5;
    repeat (2) @(posedge clk);
    #3;
    ctl("rst_ctl", 1'b0, 1'b0, 13'h0);
    wd("rst_wd", 8'h0);
    g("rst_gnt", 2'b00);
    chk("rst_rv_a", 32'({rvalid_a, rdata_a}), 32'(0));
    chk("rst_rv_b", 32'({rvalid_b, rdata_b}), 32'(0));
    @(posedge clk);
    #1 rst_n_sync = 1'b1;

    // first tie after reset goes to requester 0, then requester 1 with no bubble
    cyc(2'b11, 2'b00, 2'b11, 13'h020, 13'h021, 8'h11, 8'h22); g("tie", 2'b01);
    ref_mem[13'h020] = 8'h11;
    cyc(2'b10, 2'b00, 2'b11, 13'h020, 13'h021, 8'h11, 8'h22); g("tie_hold", 2'b01);
    ctl("tie_w0", 1'b1, 1'b0, 13'h020); wd("tie_d0", 8'h11);
    cyc(2'b10, 2'b00, 2'b11, 13'h020, 13'h021, 8'h11, 8'h22); g("tie_sw", 2'b10);
    quiet("tie_gap");
    ref_mem[13'h021] = 8'h22;
    nop(); ctl("tie_w1", 1'b1, 1'b0, 13'h021); wd("tie_d1", 8'h22);
    nop(); g("tie_idle", 2'b00);

    // single read of the preloaded word
    cyc(2'b01, 2'b00, 2'b00, 13'h010, 13'h0, 8'h0, 8'h0); g("rd_gnt", 2'b01);
    push_rd(1'b0, 13'h010);
    nop(); ctl("rd_ctl", 1'b0, 1'b1, 13'h010);
    nop(); quiet("rd_pulse");

    // burst cap: exactly four unlocked writes while requester 1 waits
    for (int k = 0; k < 4; k++) begin
      cyc(k == 0 ? 2'b01 : 2'b11, 2'b00, 2'b01, 13'(256 + k), 13'h101, 8'(64 + k), 8'h0);
      g("cap_own0", 2'b01);
      if (k > 0) begin
        ctl("cap_w", 1'b1, 1'b0, 13'(255 + k));
        wd("cap_d", 8'(63 + k));
      end
      ref_mem[256 + k] = 8'(64 + k);
    end
    cyc(2'b11, 2'b00, 2'b01, 13'h104, 13'h101, 8'h44, 8'h0); g("cap_own1", 2'b10);
    ctl("cap_w3", 1'b1, 1'b0, 13'h103);
    push_rd(1'b1, 13'h101);
    cyc(2'b01, 2'b00, 2'b01, 13'h104, 13'h101, 8'h44, 8'h0); g("cap_hold1", 2'b10);
    ctl("cap_r1", 1'b0, 1'b1, 13'h101);
    cyc(2'b01, 2'b00, 2'b01, 13'h104, 13'h101, 8'h44, 8'h0); g("cap_back0", 2'b01);
    quiet("cap_gap");
    ref_mem[13'h104] = 8'h44;
    nop(); ctl("cap_w4", 1'b1, 1'b0, 13'h104); wd("cap_d4", 8'h44);

    // lock holds the port through idle cycles
    cyc(2'b01, 2'b01, 2'b01, 13'h200, 13'h0, 8'h77, 8'h0); g("lk_gnt", 2'b01);
    ref_mem[13'h200] = 8'h77;
    for (int k = 0; k < 3; k++) begin
      cyc(2'b10, 2'b01, 2'b01, 13'h200, 13'h0, 8'h77, 8'h0); g("lk_hold", 2'b01);
    end
    cyc(2'b11, 2'b01, 2'b01, 13'h200, 13'h0, 8'h77, 8'h0); g("lk_beat", 2'b01);
    cyc(2'b10, 2'b00, 2'b01, 13'h200, 13'h0, 8'h77, 8'h0); g("lk_drop", 2'b01);
    ctl("lk_w", 1'b1, 1'b0, 13'h200);
    cyc(2'b10, 2'b00, 2'b00, 13'h200, 13'h010, 8'h77, 8'h0); g("lk_own1", 2'b10);
    push_rd(1'b1, 13'h010);
    nop(); ctl("lk_r", 1'b0, 1'b1, 13'h010);

    // reads in flight across a capped ownership switch
    for (int k = 0; k < 4; k++) begin
      cyc(2'b11, 2'b00, 2'b00, 13'(2 + k), 13'h006, 8'h0, 8'h0); g("sw_own0", 2'b01);
      push_rd(1'b0, 13'(2 + k));
    end
    cyc(2'b10, 2'b00, 2'b00, 13'h005, 13'h006, 8'h0, 8'h0); g("sw_own1", 2'b10);
    ctl("sw_r5", 1'b0, 1'b1, 13'h005);
    push_rd(1'b1, 13'h006);
    nop(); ctl("sw_r6", 1'b0, 1'b1, 13'h006);
    repeat (8) nop();

    // reset with two reads in flight drops them
    cyc(2'b01, 2'b00, 2'b00, 13'h010, 13'h0, 8'h0, 8'h0);
    cyc(2'b01, 2'b00, 2'b00, 13'h011, 13'h0, 8'h0, 8'h0);
    @(posedge clk);
    #1;
    req = '0;
    rst_n_sync = 1'b0;
    #1;
    ctl("mid_rst", 1'b0, 1'b0, 13'h0);
    chk("mid_rst_rv", 32'({rvalid_a, rvalid_b}), 32'(0));
    @(posedge clk);
    #1 rst_n_sync = 1'b1;
    repeat (6) nop();
    cyc(2'b11, 2'b00, 2'b00, 13'h006, 13'h005, 8'h0, 8'h0); g("rst_tie", 2'b01);
    push_rd(1'b0, 13'h006);
    cyc(2'b00, 2'b00, 2'b00, 13'h006, 13'h005, 8'h0, 8'h0);
    ctl("rst_tie_r", 1'b0, 1'b1, 13'h006);
    repeat (8) nop();
    chk("drain_a", 32'(qa.size()), 32'(0));
    chk("drain_b", 32'(qb.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bram_port_arbiter.md
Name: bram_port_arbiter

Overview:
- Shares the single 13-bit x 8-bit block RAM port between two requesters.
  - Requester 0: the SCARF BRAM slave.
  - Requester 1: a local capture/playback engine.
- Round-robin arbitration with burst lock and a burst cap.
- Issues registered BRAM controls.
- Routes returning read data to the requester that issued each read, even across ownership switches.

Parameters:
- ADDR_W, 13, BRAM address width.
- DATA_W, 8, BRAM data width.
- RD_LATENCY, 1, cycles from bram_ren asserted to bram_read_data valid (legal 1..3).
- MAX_BURST, 16, max consecutive unlocked beats for one owner while the other requester is waiting (legal 2..255).

Ports:
- clk  input  1  clock
- rst_n_sync  input  1  asynchronous active-low reset
- req_i  input  2  per-requester access request, one beat per cycle while req_i & gnt_o
- lock_i  input  2  per-requester hold ownership (e.g. for a SCARF transaction), even across idle cycles
- wen_i  input  2  per-requester 1 = write beat, 0 = read beat
- addr_i  input  2xADDR_W  per-requester address
- wdata_i  input  2xDATA_W  per-requester write data
- gnt_o  output  2  per-requester grant; a beat transfers when req_i[i] & gnt_o[i]
- rvalid_o  output  2  per-requester read data valid, one pulse per read beat
- rdata_o  output  DATA_W  read data, shared by both requesters, qualified by rvalid_o
- bram_read_data  input  DATA_W  BRAM read data
- bram_addr  output  ADDR_W  BRAM address
- bram_write_data  output  DATA_W  BRAM write data
- bram_wen  output  1  BRAM write enable
- bram_ren  output  1  BRAM read enable

Behaviour:
- Reset (rst_n_sync asynchronous, active-low; clock clk):
  - state=IDLE, last_owner=1 (so requester 0 wins the first tie), beat_cnt=0.
  - bram_addr=0, bram_write_data=0, bram_wen=0, bram_ren=0.
  - rvalid_o=0, read-tag pipeline cleared.
  - rdata_o reset value: 0.
  - Reset mid-operation discards all in-flight reads; no rvalid_o is produced for them.
- States: IDLE, OWN0, OWN1.
- gnt_o is combinational:
  - OWNi: gnt_o[i]=1, other=0.
  - IDLE: grant the sole requester; if both request, grant !last_owner; if neither, gnt_o=0.
- Beat transfer in cycle N (req_i[i] & gnt_o[i]):
  - Cycle N+1: bram_addr/bram_write_data/bram_wen=wen_i[i]/bram_ren=!wen_i[i] are registered from requester i.
  - Controls are single-cycle pulses; bram_wen and bram_ren are both 0 in non-transfer cycles.
  - bram_addr and bram_write_data hold their last values in non-transfer cycles.
- Read return:
  - Each read beat pushes {valid=1, owner=i} into a tag pipeline of depth RD_LATENCY.
  - rvalid_o[owner] pulses in cycle N+1+RD_LATENCY.
  - rdata_o is registered from bram_read_data in that same cycle; it is valid at the rvalid_o pulse.
  - Writes never produce rvalid_o.
- Transitions:
  - IDLE -> OWNi when granted requester i transfers in that cycle; last_owner<=i, beat_cnt<=1.
  - OWNi:
    - Stay while lock_i[i]=1. beat_cnt is not incremented while locked; the cap does not apply.
    - If lock_i[i]=0 and req_i[i]=0: go to OWN(other) if req_i[other]=1, else IDLE.
    - If lock_i[i]=0, a beat transfers, req_i[other]=1 and beat_cnt==MAX_BURST-1: go to OWN(other) after that beat; beat_cnt<=0.
    - Otherwise beat_cnt increments per transfer, saturating at MAX_BURST-1.
  - Entering OWNj: last_owner<=j, beat_cnt<=0.
  - Switch has zero bubble: the new owner may transfer in the cycle after the switch.
- The owner changing while reads are in flight must not misroute data; the tag owner governs routing.
- Back-to-back mixed read/write beats from one owner are legal every cycle.
- Both lock_i bits high: the current owner keeps the port; the other waits indefinitely (documented, not an error).

Decomposition:
- Package bram_arb_pkg:
  - state enum arb_state_t {IDLE, OWN0, OWN1}.
  - Constants ADDR_W=13, DATA_W=8.
  - Typedef rd_tag_t {logic valid; logic owner;}.
- Sub-module bram_rd_tag_pipe:
  - Parameterised RD_LATENCY shift register of rd_tag_t, async reset.
  - Produces the rvalid_o decode.

Test Plan:
- Single requester 0 reads addr 0x0010 with RD_LATENCY=1 -> gnt_o[0] same cycle; bram_ren=1 with bram_addr=0x0010 at N+1; rvalid_o[0]=1 at N+2 with rdata_o=BRAM content (preload 0xA5).
- Both requesters raise req_i in the same cycle after reset -> requester 0 granted first. Requester 0 deasserts after 1 beat -> requester 1 granted next cycle, no bubble, last_owner=1.
- MAX_BURST=4: requester 0 streams unlocked writes to 0x0100.. while requester 1 holds req -> exactly 4 writes (0x0100-0x0103), then OWN1 for requester 1's beats.
- Requester 0 lock_i=1 with 3 idle cycles mid-burst while requester 1 requests -> gnt_o[1] stays 0 until lock_i[0] drops.
- RD_LATENCY=3: requester 0 reads 0x0005, ownership switches, requester 1 reads 0x0006 the next cycle -> rvalid_o[0] then rvalid_o[1] on consecutive cycles with the correct data each.
- Assert rst_n_sync low for 1 cycle with 2 reads in flight -> all BRAM controls 0 immediately; no rvalid_o afterward; the next tie is granted to requester 0.
